// File: rtl/serpario_if.sv
// CPU-side register bus of the serpario expander controller.
// Carries the output write strobe/data and the captured input/status back.
// master = CPU/register block, slave = serpario_ctrl.
interface serpario_if #(
   parameter int OUT_WIDTH = 8,
   parameter int IN_WIDTH  = 8
) ();
   logic [OUT_WIDTH-1:0] out_data_i;
   logic                 out_wr_i;
   logic [IN_WIDTH-1:0]  in_data_o;
   logic                 busy_o;
   logic                 done_o;
   logic                 irq_o;

   modport master (
      output out_data_i, out_wr_i,
      input  in_data_o, busy_o, done_o, irq_o
   );

   modport slave (
      input  out_data_i, out_wr_i,
      output in_data_o, busy_o, done_o, irq_o
   );
endinterface

// File: rtl/serpario_ctrl.sv
// Serial/parallel expander controller: one burst shifts a 595 output chain and reads a 165 input chain.
// Transfer is CLK_DIV*(2*NBITS+2)+1 cycles from start decision to DONE; all pin/status outputs registered.
// Writes during a transfer are posted one deep (latest wins); no backpressure to the CPU.
module serpario_ctrl #(
   parameter int OUT_WIDTH      = 8,
   parameter int IN_WIDTH       = 8,
   parameter int CLK_DIV        = 4,
   parameter int AUTO_REFRESH   = 1,
   parameter int REFRESH_CYCLES = 50000
) (
   input  logic       clk_i,
   input  logic       reset,
   serpario_if.slave  bus,
   output logic       ser_out_o,
   input  logic       ser_in_i,
   output logic       sh_clk_o,
   output logic       store_o,
   output logic       load_n_o,
   output logic       out_en_o
);
   localparam int NBITS = (OUT_WIDTH > IN_WIDTH) ? OUT_WIDTH : IN_WIDTH;
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
   localparam int REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);
   localparam logic [BIT_W:0]   IN_CNT   = (BIT_W + 1)'(IN_WIDTH);
   localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_SHIFT = 3'd2;
   localparam logic [2:0] ST_STORE = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   logic [2:0]           state_q,    state_d;
   logic [DIV_W-1:0]     div_q,      div_d;
   logic [BIT_W-1:0]     bit_q,      bit_d;
   logic                 phase_q,    phase_d;     // 0: SH_CLK low half, 1: high half
   logic [REF_W-1:0]     refr_q,     refr_d;
   logic [OUT_WIDTH-1:0] shadow_q,   shadow_d;
   logic                 pend_vld_q, pend_vld_d;
   logic [OUT_WIDTH-1:0] pend_q,     pend_d;
   logic [IN_WIDTH-1:0]  in_sh_q,    in_sh_d;
   logic [IN_WIDTH-1:0]  in_data_q,  in_data_d;
   logic                 busy_q,     busy_d;
   logic                 done_q,     done_d;
   logic                 irq_q,      irq_d;
   logic                 ser_out_q,  ser_out_d;
   logic                 sh_clk_q,   sh_clk_d;
   logic                 store_q,    store_d;
   logic                 load_n_q,   load_n_d;
   logic                 out_en_q,   out_en_d;

   logic                 start;
   logic [NBITS-1:0]     out_seq;

   // Next-state, counters, shadow/pending bookkeeping and registered output decode
   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      bit_d      = bit_q;
      phase_d    = phase_q;
      refr_d     = refr_q;
      shadow_d   = shadow_q;
      pend_vld_d = pend_vld_q;
      pend_d     = pend_q;
      in_sh_d    = in_sh_q;
      in_data_d  = in_data_q;
      out_en_d   = out_en_q;
      irq_d      = 1'b0;
      start      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // A fresh write beats a posted one; either beats a plain refresh.
            if (bus.out_wr_i) begin
               shadow_d   = bus.out_data_i;
               pend_vld_d = 1'b0;
               start      = 1'b1;
            end else if (pend_vld_q) begin
               shadow_d   = pend_q;
               pend_vld_d = 1'b0;
               start      = 1'b1;
            end else if ((AUTO_REFRESH != 0) && (refr_q == REF_LAST)) begin
               start = 1'b1;
            end
            if (start) begin
               state_d = ST_LOAD;
               div_d   = '0;
               refr_d  = '0;
            end else if (refr_q != REF_LAST) begin
               refr_d = refr_q + 1'b1;
            end
         end
         ST_LOAD: begin
            if (div_q == DIV_LAST) begin
               state_d = ST_SHIFT;
               div_d   = '0;
               bit_d   = '0;
               phase_d = 1'b0;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         ST_SHIFT: begin
            // Input bit is taken just before SH_CLK rises; only the first IN_WIDTH are kept.
            if (!phase_q && (div_q == DIV_LAST) && ({1'b0, bit_q} < IN_CNT)) begin
               in_sh_d = (in_sh_q << 1) | IN_WIDTH'(ser_in_i);
            end
            if (div_q == DIV_LAST) begin
               div_d = '0;
               if (!phase_q) begin
                  phase_d = 1'b1;
               end else begin
                  phase_d = 1'b0;
                  if (bit_q == BIT_LAST) begin
                     state_d = ST_STORE;
                  end else begin
                     bit_d = bit_q + 1'b1;
                  end
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         ST_STORE: begin
            if (div_q == DIV_LAST) begin
               state_d = ST_DONE;
               div_d   = '0;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Writes arriving outside IDLE are posted; a newer one overwrites.
      if (bus.out_wr_i && (state_q != ST_IDLE)) begin
         pend_d     = bus.out_data_i;
         pend_vld_d = 1'b1;
      end

      // Leading zeros pad a short output chain so the shadow lands at the far end.
      out_seq = NBITS'(shadow_d);

      busy_d    = (state_d != ST_IDLE);
      done_d    = (state_d == ST_DONE);
      load_n_d  = (state_d != ST_LOAD);
      store_d   = (state_d == ST_STORE);
      sh_clk_d  = (state_d == ST_SHIFT) && phase_d;
      ser_out_d = (state_d == ST_SHIFT) ? out_seq[BIT_LAST - bit_d] : 1'b0;

      if (state_d == ST_DONE) begin
         in_data_d = in_sh_q;
         irq_d     = (in_sh_q != in_data_q);
         out_en_d  = 1'b0;
      end
   end

   // State and output registers with synchronous reset (aborts any transfer)
   always_ff @(posedge clk_i) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         div_q      <= '0;
         bit_q      <= '0;
         phase_q    <= 1'b0;
         refr_q     <= '0;
         shadow_q   <= '0;
         pend_vld_q <= 1'b0;
         pend_q     <= '0;
         in_sh_q    <= '0;
         in_data_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         irq_q      <= 1'b0;
         ser_out_q  <= 1'b0;
         sh_clk_q   <= 1'b0;
         store_q    <= 1'b0;
         load_n_q   <= 1'b1;
         out_en_q   <= 1'b1;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         phase_q    <= phase_d;
         refr_q     <= refr_d;
         shadow_q   <= shadow_d;
         pend_vld_q <= pend_vld_d;
         pend_q     <= pend_d;
         in_sh_q    <= in_sh_d;
         in_data_q  <= in_data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         irq_q      <= irq_d;
         ser_out_q  <= ser_out_d;
         sh_clk_q   <= sh_clk_d;
         store_q    <= store_d;
         load_n_q   <= load_n_d;
         out_en_q   <= out_en_d;
      end
   end

   assign bus.in_data_o = in_data_q;
   assign bus.busy_o    = busy_q;
   assign bus.done_o    = done_q;
   assign bus.irq_o     = irq_q;
   assign ser_out_o     = ser_out_q;
   assign sh_clk_o      = sh_clk_q;
   assign store_o       = store_q;
   assign load_n_o      = load_n_q;
   assign out_en_o      = out_en_q;
endmodule

// File: tb/tb_serpario_ctrl.sv
// Directed bench for serpario_ctrl: three instances (8/8 write-only, 12/4 write-only, 8/8 auto-refresh).
// Each instance has a 165-style input chain model and a 595-style capture/latch monitor.
// Checks reset state, bit order, timing, irq, posting, refresh period and mid-shift reset.
module tb_serpario_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic [15:0] par [3];

   always #5 clk = ~clk;

   serpario_if #(.OUT_WIDTH(8),  .IN_WIDTH(8)) if0 ();
   serpario_if #(.OUT_WIDTH(12), .IN_WIDTH(4)) if1 ();
   serpario_if #(.OUT_WIDTH(8),  .IN_WIDTH(8)) if2 ();

   wire [2:0] ser_out_w, ser_in_w, sh_clk_w, store_w, load_n_w, out_en_w, busy_w, done_w, irq_w;

   serpario_ctrl #(.OUT_WIDTH(8), .IN_WIDTH(8), .CLK_DIV(2), .AUTO_REFRESH(0), .REFRESH_CYCLES(100)) u0 (
      .clk_i(clk), .reset(rst), .bus(if0.slave),
      .ser_out_o(ser_out_w[0]), .ser_in_i(ser_in_w[0]), .sh_clk_o(sh_clk_w[0]),
      .store_o(store_w[0]), .load_n_o(load_n_w[0]), .out_en_o(out_en_w[0]));

   serpario_ctrl #(.OUT_WIDTH(12), .IN_WIDTH(4), .CLK_DIV(2), .AUTO_REFRESH(0), .REFRESH_CYCLES(100)) u1 (
      .clk_i(clk), .reset(rst), .bus(if1.slave),
      .ser_out_o(ser_out_w[1]), .ser_in_i(ser_in_w[1]), .sh_clk_o(sh_clk_w[1]),
      .store_o(store_w[1]), .load_n_o(load_n_w[1]), .out_en_o(out_en_w[1]));

   serpario_ctrl #(.OUT_WIDTH(8), .IN_WIDTH(8), .CLK_DIV(2), .AUTO_REFRESH(1), .REFRESH_CYCLES(100)) u2 (
      .clk_i(clk), .reset(rst), .bus(if2.slave),
      .ser_out_o(ser_out_w[2]), .ser_in_i(ser_in_w[2]), .sh_clk_o(sh_clk_w[2]),
      .store_o(store_w[2]), .load_n_o(load_n_w[2]), .out_en_o(out_en_w[2]));

   assign busy_w = {if2.busy_o, if1.busy_o, if0.busy_o};
   assign done_w = {if2.done_o, if1.done_o, if0.done_o};
   assign irq_w  = {if2.irq_o,  if1.irq_o,  if0.irq_o};

   for (genvar g = 0; g < 3; g++) begin : g_mon
      localparam int W = (g == 1) ? 4 : 8;
      logic [15:0] sr = '0;
      logic        sh_pq = 1'b0;
      logic [15:0] cap = '0;
      logic [15:0] lat = '0;
      logic        sh_nq = 1'b0;
      logic        oe_nq = 1'b1;
      logic        oe_before = 1'b0;
      logic        oe_at = 1'b1;
      int rises = 0, dones = 0, irqs = 0, brun = 0, blen = 0, srun = 0, slen = 0;

      assign ser_in_w[g] = sr[W-1];

      // 165 model: parallel load while LOAD_N low, shift (fill with 1s) on SH_CLK rise
      always @(posedge clk) begin
         sh_pq <= sh_clk_w[g];
         if (!load_n_w[g]) sr <= par[g];
         else if (sh_clk_w[g] && !sh_pq) sr <= {sr[14:0], 1'b1};
      end

      // 595 model and pulse-length / event counters
      always @(negedge clk) begin
         sh_nq <= sh_clk_w[g];
         oe_nq <= out_en_w[g];
         if (sh_clk_w[g] && !sh_nq) begin
            cap   <= {cap[14:0], ser_out_w[g]};
            rises <= rises + 1;
         end
         if (store_w[g]) begin
            if (srun == 0) lat <= cap;
            srun <= srun + 1;
         end else if (srun != 0) begin
            slen <= srun;
            srun <= 0;
         end
         if (busy_w[g]) brun <= brun + 1;
         else if (brun != 0) begin
            blen <= brun;
            brun <= 0;
         end
         if (done_w[g]) begin
            dones     <= dones + 1;
            oe_before <= oe_nq;
            oe_at     <= out_en_w[g];
         end
         if (irq_w[g]) irqs <= irqs + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int idx, input logic [15:0] v);
      @(negedge clk);
      case (idx)
         0: begin if0.out_data_i = v[7:0];  if0.out_wr_i = 1'b1; end
         1: begin if1.out_data_i = v[11:0]; if1.out_wr_i = 1'b1; end
         default: begin if2.out_data_i = v[7:0]; if2.out_wr_i = 1'b1; end
      endcase
      @(negedge clk);
      if0.out_wr_i = 1'b0;
      if1.out_wr_i = 1'b0;
      if2.out_wr_i = 1'b0;
   endtask

   initial begin
      int k;
      rst = 1'b1;
      if0.out_wr_i = 1'b0; if0.out_data_i = '0;
      if1.out_wr_i = 1'b0; if1.out_data_i = '0;
      if2.out_wr_i = 1'b0; if2.out_data_i = '0;
      par[0] = 16'h003C;
      par[1] = 16'h0009;
      par[2] = 16'h0042;
      repeat (4) @(negedge clk);

      // Reset state
      chk("rst_busy",   32'(busy_w[0]),     32'd0);
      chk("rst_load_n", 32'(load_n_w[0]),   32'd1);
      chk("rst_out_en", 32'(out_en_w[0]),   32'd1);
      chk("rst_sh_clk", 32'(sh_clk_w[0]),   32'd0);
      chk("rst_in",     32'(if0.in_data_o), 32'd0);
      rst = 1'b0;

      // Auto-refresh: first start after 100 idle cycles, then every 100 idle + 37 busy
      k = -1;
      for (int i = 1; i <= 400; i++) begin
         @(negedge clk);
         if (done_w[2]) begin k = i; break; end
      end
      chk("refresh_first", 32'(k), 32'd136);
      k = -1;
      for (int i = 1; i <= 400; i++) begin
         @(negedge clk);
         if (done_w[2]) begin k = i; break; end
      end
      chk("refresh_period", 32'(k), 32'd137);
      chk("refresh_busy",   32'(g_mon[2].blen),  32'd37);
      chk("refresh_shadow", 32'(g_mon[2].lat),   32'h0);
      chk("refresh_in",     32'(if2.in_data_o),  32'h42);
      chk("refresh_irq",    32'(g_mon[2].irqs),  32'd1);

      // Single write 0xA5 with input 0x3C
      wr(0, 16'h00A5);
      repeat (50) @(negedge clk);
      chk("a5_bits",      32'(g_mon[0].lat[7:0]), 32'hA5);
      chk("a5_rises",     32'(g_mon[0].rises),    32'd8);
      chk("a5_busy",      32'(g_mon[0].blen),     32'd37);
      chk("a5_store",     32'(g_mon[0].slen),     32'd2);
      chk("a5_dones",     32'(g_mon[0].dones),    32'd1);
      chk("oe_before",    32'(g_mon[0].oe_before), 32'd1);
      chk("oe_at_done",   32'(g_mon[0].oe_at),    32'd0);
      chk("a5_in",        32'(if0.in_data_o),     32'h3C);
      chk("a5_irq",       32'(g_mon[0].irqs),     32'd1);

      // Same input again: no irq
      wr(0, 16'h00A5);
      repeat (50) @(negedge clk);
      chk("rep_dones", 32'(g_mon[0].dones), 32'd2);
      chk("rep_irq",   32'(g_mon[0].irqs),  32'd1);
      chk("rep_in",    32'(if0.in_data_o),  32'h3C);

      // Posting: 0x11 then 0x22, 0x33 while busy -> two transfers, last sends 0x33
      par[0] = 16'h0081;
      wr(0, 16'h0011);
      repeat (4) @(negedge clk);
      wr(0, 16'h0022);
      repeat (2) @(negedge clk);
      wr(0, 16'h0033);
      repeat (120) @(negedge clk);
      chk("post_dones", 32'(g_mon[0].dones),     32'd4);
      chk("post_bits",  32'(g_mon[0].lat[7:0]),  32'h33);
      chk("post_in",    32'(if0.in_data_o),      32'h81);
      chk("post_irq",   32'(g_mon[0].irqs),      32'd2);

      // Long output chain, short input chain
      wr(1, 16'h0FFF);
      repeat (70) @(negedge clk);
      chk("w12_rises", 32'(g_mon[1].rises),      32'd12);
      chk("w12_bits",  32'(g_mon[1].lat[11:0]),  32'hFFF);
      chk("w12_busy",  32'(g_mon[1].blen),       32'd53);
      chk("w12_in",    32'(if1.in_data_o),       32'h9);
      chk("w12_irq",   32'(g_mon[1].irqs),       32'd1);

      // Reset in the middle of SHIFT
      wr(0, 16'h005A);
      k = -1;
      for (int i = 0; i < 50; i++) begin
         if (sh_clk_w[0]) begin k = i; break; end
         @(negedge clk);
      end
      chk("mid_found", 32'(k >= 0), 32'd1);
      chk("mid_busy",  32'(busy_w[0]), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_sh_clk", 32'(sh_clk_w[0]),   32'd0);
      chk("mid_load_n", 32'(load_n_w[0]),   32'd1);
      chk("mid_out_en", 32'(out_en_w[0]),   32'd1);
      chk("mid_busy0",  32'(busy_w[0]),     32'd0);
      chk("mid_in",     32'(if0.in_data_o), 32'h0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
